// File: rtl/wb_select_if.sv
// Writeback select stage bus: upstream request fields, downstream register-file write
// and the valid/ready handshake on both sides.
interface wb_select_if #(
  parameter int XLEN = 32,
  parameter int NSRC = 4,
  parameter int RA_W = 5
);
  localparam int SELW = $clog2(NSRC);

  logic                 in_valid;
  logic                 in_ready;
  logic [NSRC*XLEN-1:0] in_src;
  logic [SELW-1:0]      in_sel;
  logic [2:0]           in_ld_fmt;
  logic [1:0]           in_addr_lo;
  logic [RA_W-1:0]      in_rd;
  logic                 in_we;
  logic                 out_ready;
  logic                 out_valid;
  logic                 rf_we;
  logic [RA_W-1:0]      rf_rd;
  logic [XLEN-1:0]      rf_wdata;
  logic                 out_err;

  // Pipeline side: the stage itself.
  modport slave (
    input  in_valid, in_src, in_sel, in_ld_fmt, in_addr_lo, in_rd, in_we, out_ready,
    output in_ready, out_valid, rf_we, rf_rd, rf_wdata, out_err
  );

  // Environment side: execute/memory upstream plus the register file downstream.
  modport master (
    output in_valid, in_src, in_sel, in_ld_fmt, in_addr_lo, in_rd, in_we, out_ready,
    input  in_ready, out_valid, rf_we, rf_rd, rf_wdata, out_err
  );
endinterface

// File: rtl/wb_select_stage.sv
// Registered RV32I writeback select: source mux, load byte/half formatting and a
// two-entry (output register + skid) valid/ready pipeline stage toward the register file.
module wb_select_stage #(
  parameter int XLEN    = 32,
  parameter int NSRC    = 4,
  parameter int MEM_IDX = 1,
  parameter int RA_W    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_select_if.slave   bus
);
  localparam int SELW = $clog2(NSRC);

  typedef struct packed {
    logic            we;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            err;
  } entry_t;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_fmt_e;

  logic [XLEN-1:0] w_sel_data;
  logic            w_sel_ok;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  entry_t          w_new;
  logic            w_accept;
  logic            w_drain;

  entry_t r_out;
  entry_t r_skid;
  logic   r_out_valid;
  logic   r_skid_valid;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_sel_data = '0;
    w_sel_ok   = 1'b0;
    // Loop match instead of a range compare keeps non-power-of-two NSRC safe.
    for (int k = 0; k < NSRC; k++) begin
      if (int'(bus.in_sel) == k) begin
        w_sel_data = bus.in_src[k*XLEN +: XLEN];
        w_sel_ok   = 1'b1;
      end
    end
  end

  assign w_word = w_sel_data[31:0];
  assign w_byte = w_word[8*bus.in_addr_lo +: 8];
  assign w_half = bus.in_addr_lo[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_new.we   = bus.in_we;
    w_new.rd   = bus.in_rd;
    w_new.data = w_sel_data;
    w_new.err  = !w_sel_ok;
    if (w_sel_ok && (int'(bus.in_sel) == MEM_IDX)) begin
      case (ld_fmt_e'(bus.in_ld_fmt))
        LD_B:  w_new.data = XLEN'($signed(w_byte));
        LD_BU: w_new.data = XLEN'(w_byte);
        LD_H: begin
          w_new.data = XLEN'($signed(w_half));
          w_new.err  = bus.in_addr_lo[0];
        end
        LD_HU: begin
          w_new.data = XLEN'(w_half);
          w_new.err  = bus.in_addr_lo[0];
        end
        LD_W: begin
          w_new.data = XLEN'($signed(w_word));
          w_new.err  = (bus.in_addr_lo != 2'b00);
        end
        default: w_new.err = 1'b1;
      endcase
    end
  end

  assign bus.in_ready = !r_skid_valid;
  assign w_accept     = bus.in_valid && !r_skid_valid;
  assign w_drain      = r_out_valid && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_drain) begin
      // A full skid blocks new accepts, so skid refill and accept never collide.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_new;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.rf_rd     = r_out.rd;
  assign bus.rf_wdata  = r_out.data;
  assign bus.out_err   = r_out.err;
  assign bus.rf_we     = w_drain && r_out.we && (r_out.rd != '0) && !r_out.err;
endmodule
